// File: rtl/pipeline_valid_ctrl_pkg.sv
// Shared CPU constants: pipeline stage indices and the canonical NOP.
// Latency: none (constants only).
// Backpressure: not applicable.
package cpu_pkg;

    // Bit positions of each stage inside the per-stage valid vector.
    localparam int STG_ID  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;
    localparam int NUM_STG = 4;

    // addi x0, x0, 0 -- what a bubbled ID/EX register carries.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_valid_ctrl_if.sv
// Handshake bundle between the hazard unit / fetch path and the valid controller.
// Latency: none (wires only).
// Backpressure: stop_ID from the master stalls the front end; the slave reports status back.
interface pipeline_valid_ctrl_if;
    // Requests toward the valid controller.
    logic fetch_valid;
    logic is_load_ID;
    logic stop_ID;
    logic set_invalid_ID;
    logic set_invalid_EX;
    logic set_invalid_MEM;
    logic took_branch;
    // Enables and status coming back.
    logic pc_en;
    logic pc_sel_branch;
    logic if_id_en;
    logic id_ex_bubble;
    logic EX_invalid;
    logic MEM_invalid;
    logic is_load_EX;
    logic is_load_MEM;
    logic mem_access_en;
    logic wb_en;

    modport master (
        output fetch_valid, is_load_ID, stop_ID, set_invalid_ID, set_invalid_EX,
               set_invalid_MEM, took_branch,
        input  pc_en, pc_sel_branch, if_id_en, id_ex_bubble, EX_invalid, MEM_invalid,
               is_load_EX, is_load_MEM, mem_access_en, wb_en
    );

    modport slave (
        input  fetch_valid, is_load_ID, stop_ID, set_invalid_ID, set_invalid_EX,
               set_invalid_MEM, took_branch,
        output pc_en, pc_sel_branch, if_id_en, id_ex_bubble, EX_invalid, MEM_invalid,
               is_load_EX, is_load_MEM, mem_access_en, wb_en
    );
endinterface

// File: rtl/pipeline_valid_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc one clock after it is seen.
// Backpressure: none; once at all-ones further increments are dropped.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count qualifying cycles, parking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_valid_ctrl.sv
// Per-stage valid tracking, front-end enables, wrong-path fetch kill and stall/flush counters.
// Latency: enables are combinational; valid/status bits update on the next clock edge.
// Backpressure: stop_ID holds PC and IF/ID and bubbles ID/EX; a taken branch overrides the stall.
module pipeline_valid_ctrl
    import cpu_pkg::*;
#(
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_valid_ctrl_if.slave pv,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [2:0] KILL_LOAD = 3'(FETCH_LAT);

    logic [NUM_STG-1:0] v_q;
    logic               ld_ex_q;
    logic               ld_mem_q;
    logic [2:0]         kill_cnt;
    logic               flush;
    logic               stall;

    // Front-end control; a redirect always beats a load-use stall. Enables stay low in reset.
    always_comb begin
        flush            = pv.took_branch | pv.set_invalid_ID;
        stall            = pv.stop_ID & ~pv.took_branch;
        pv.pc_en         = reset & ~stall;
        pv.if_id_en      = reset & ~stall;
        pv.pc_sel_branch = pv.took_branch;
        pv.id_ex_bubble  = stall | pv.set_invalid_EX;
    end

    // Status back to the hazard unit is decoded purely from registers.
    always_comb begin
        pv.EX_invalid    = ~v_q[STG_EX];
        pv.MEM_invalid   = ~v_q[STG_MEM];
        pv.is_load_EX    = v_q[STG_EX] & ld_ex_q;
        pv.is_load_MEM   = v_q[STG_MEM] & ld_mem_q;
        pv.mem_access_en = v_q[STG_MEM];
        pv.wb_en         = v_q[STG_WB];
    end

    // Advance valid bits; on a stall ID holds and EX takes a bubble while MEM/WB drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= '0;
            ld_ex_q  <= 1'b0;
            ld_mem_q <= 1'b0;
        end else begin
            v_q[STG_WB]  <= v_q[STG_MEM];
            v_q[STG_MEM] <= v_q[STG_EX] & ~pv.set_invalid_MEM & ~pv.took_branch;
            ld_mem_q     <= ld_ex_q;
            if (stall) begin
                v_q[STG_EX] <= 1'b0;
            end else begin
                v_q[STG_EX] <= v_q[STG_ID] & ~pv.set_invalid_EX & ~pv.took_branch;
                ld_ex_q     <= pv.is_load_ID;
                v_q[STG_ID] <= pv.fetch_valid & (kill_cnt == 3'd0) & ~flush;
            end
        end
    end

    // Wrong-path window: reloaded by every taken branch, otherwise counts down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kill_cnt <= 3'd0;
        end else if (pv.took_branch) begin
            kill_cnt <= KILL_LOAD;
        end else if (kill_cnt != 3'd0) begin
            kill_cnt <= kill_cnt - 3'd1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pv.took_branch),
        .clr   (1'b0),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_valid_ctrl.sv
// Randomized and directed bench for pipeline_valid_ctrl against a stage-list reference model.
// Latency: model state is compared one half-cycle after each rising edge.
// Backpressure: stall and redirect scenarios are driven explicitly and at random.
module tb_pipeline_valid_ctrl;

    localparam int FETCH_LAT = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    pipeline_valid_ctrl_if pv ();

    pipeline_valid_ctrl #(.FETCH_LAT(FETCH_LAT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pv          (pv.slave),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one (valid, load) slot per stage ID..WB, a cycle clock,
    // and the cycle number of the last redirect to decide wrong-path fetches.
    bit m_vld [4];
    bit m_ld  [4];
    int m_stalls;
    int m_flushes;
    int m_cyc;
    int m_last_br;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 1'b0;
            m_ld[i]  = 1'b0;
        end
        m_stalls  = 0;
        m_flushes = 0;
        m_cyc     = 0;
        m_last_br = -100;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ex_invalid",  32'(pv.EX_invalid),    32'd1);
        check_eq("rst_mem_invalid", 32'(pv.MEM_invalid),   32'd1);
        check_eq("rst_pc_en",       32'(pv.pc_en),         32'd0);
        check_eq("rst_if_id_en",    32'(pv.if_id_en),      32'd0);
        check_eq("rst_ld_ex",       32'(pv.is_load_EX),    32'd0);
        check_eq("rst_ld_mem",      32'(pv.is_load_MEM),   32'd0);
        check_eq("rst_mem_en",      32'(pv.mem_access_en), 32'd0);
        check_eq("rst_wb_en",       32'(pv.wb_en),         32'd0);
        check_eq("rst_stall_cnt",   32'(stall_count),      32'd0);
        check_eq("rst_flush_cnt",   32'(flush_count),      32'd0);
    endtask

    // One clock: drive at the falling edge, compare shortly after, then apply the model's rules at the rising edge.
    task automatic step(input bit fv, input bit ld, input bit stop, input bit si_id,
                        input bit si_ex, input bit si_mem, input bit tb);
        bit stl;
        bit accept;
        bit old_vld [4];
        bit old_ld  [4];
        @(negedge clk);
        pv.fetch_valid     = fv;
        pv.is_load_ID      = ld;
        pv.stop_ID         = stop;
        pv.set_invalid_ID  = si_id;
        pv.set_invalid_EX  = si_ex;
        pv.set_invalid_MEM = si_mem;
        pv.took_branch     = tb;
        #1;
        stl = stop && !tb;
        check_eq("pc_en",         32'(pv.pc_en),         32'(!stl));
        check_eq("if_id_en",      32'(pv.if_id_en),      32'(!stl));
        check_eq("pc_sel_branch", 32'(pv.pc_sel_branch), 32'(tb));
        check_eq("id_ex_bubble",  32'(pv.id_ex_bubble),  32'(stl || si_ex));
        check_eq("ex_invalid",    32'(pv.EX_invalid),    32'(!m_vld[1]));
        check_eq("mem_invalid",   32'(pv.MEM_invalid),   32'(!m_vld[2]));
        check_eq("is_load_ex",    32'(pv.is_load_EX),    32'(m_vld[1] && m_ld[1]));
        check_eq("is_load_mem",   32'(pv.is_load_MEM),   32'(m_vld[2] && m_ld[2]));
        check_eq("mem_access_en", 32'(pv.mem_access_en), 32'(m_vld[2]));
        check_eq("wb_en",         32'(pv.wb_en),         32'(m_vld[3]));
        check_eq("stall_count",   32'(stall_count),      32'(m_stalls));
        check_eq("flush_count",   32'(flush_count),      32'(m_flushes));
        @(posedge clk);
        old_vld = m_vld;
        old_ld  = m_ld;
        accept  = (m_cyc - m_last_br) > FETCH_LAT;
        m_vld[3] = old_vld[2];
        m_vld[2] = old_vld[1] && !si_mem && !tb;
        m_ld[2]  = old_ld[1];
        if (stl) begin
            m_vld[1] = 1'b0;
        end else begin
            m_vld[1] = old_vld[0] && !si_ex && !tb;
            m_ld[1]  = ld;
            m_vld[0] = fv && accept && !tb && !si_id;
        end
        if (stl && m_stalls < CNT_MAX) m_stalls++;
        if (tb && m_flushes < CNT_MAX) m_flushes++;
        if (tb) m_last_br = m_cyc;
        m_cyc++;
    endtask

    task automatic step_rand();
        step($urandom_range(99) < 80, $urandom_range(99) < 40, $urandom_range(99) < 15,
             $urandom_range(99) < 5, $urandom_range(99) < 5, $urandom_range(99) < 5,
             $urandom_range(99) < 10);
    endtask

    initial begin
        reset              = 1'b0;
        pv.fetch_valid     = 1'b1;
        pv.is_load_ID      = 1'b0;
        pv.stop_ID         = 1'b0;
        pv.set_invalid_ID  = 1'b0;
        pv.set_invalid_EX  = 1'b0;
        pv.set_invalid_MEM = 1'b0;
        pv.took_branch     = 1'b0;
        model_reset();
        #23;
        check_reset_outputs();
        @(posedge clk);
        #3 reset = 1'b1;

        // Straight-line code: valids ripple to WB and stay there.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0);
        #1;
        check_eq("stream_wb_en",  32'(pv.wb_en),     32'd1);
        check_eq("stream_stalls", 32'(stall_count),  32'd0);

        // Load-use: load enters ID, then one stall cycle.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Single redirect, then fetches during the kill window.
        step(1, 0, 0, 0, 0, 0, 1);
        #1;
        check_eq("br_ex_invalid",  32'(pv.EX_invalid),  32'd1);
        check_eq("br_mem_invalid", 32'(pv.MEM_invalid), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Redirect with a stall request, then a second redirect inside the window.
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Stall held long enough to saturate the counter.
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 0, 0);
        #1;
        check_eq("stall_saturated", 32'(stall_count), 32'(CNT_MAX));
        step(1, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 200; i++) step_rand();

        // Asynchronous reset in the middle of a stall and kill window.
        step(1, 0, 1, 0, 0, 0, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        pv.stop_ID     = 1'b0;
        pv.took_branch = 1'b0;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step_rand();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
